prog_loader: RTL and testbench



---
 rtl/prog_loader_pkg.sv | 21 ++
 rtl/loader_timeout.sv | 27 ++
 rtl/prog_loader.sv | 147 ++++++++++++++
 tb/tb_prog_loader.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// default frame marker and the payload split of the high byte.
package prog_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CNT_HI,
      ST_CNT_LO,
      ST_B0,
      ST_B1,
      ST_B2,
      ST_WRITE,
      ST_CHK
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   // CNT_HI and B0 carry only this many payload bits; the rest are reserved zeros
   localparam int HI_BITS = 2;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: loadable down-counter, expires when enabled at zero.
module loader_timeout #(
   parameter int W        = 20,
   parameter int LOAD_VAL = 999_999
)(
   input  logic clk_sys,
   input  logic rst_b,
   input  logic clear,
   input  logic enable,
   output logic expire
);
   localparam logic [W-1:0] LOAD = W'(LOAD_VAL);

   logic [W-1:0] cnt;

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b)
         cnt <= LOAD;
      else if (clear)
         cnt <= LOAD;
      else if (enable && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign expire = enable && (cnt == '0);

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: assembles 18-bit words from the host link,
// writes them to program memory from address 0 and holds the CPU during a load.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_IDLE   | waiting for SYNC; other bytes are dropped
//   ST_CNT_HI | expecting word-count high byte (reserved bits checked)
//   ST_CNT_LO | expecting word-count low byte
//   ST_B0     | expecting word bits [17:16] (reserved bits checked)
//   ST_B1     | expecting word bits [15:8]
//   ST_B2     | expecting word bits [7:0]
//   ST_WRITE  | one-cycle memory write, RX stalled
//   ST_CHK    | expecting XOR checksum of all data bytes
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int         ADDR_W      = 10,
   parameter int         DATA_W      = 18,
   parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
   parameter int         TIMEOUT_CYC = 1_000_000
)(
   input  logic              PROG_CLK,
   input  logic              PROG_RST_N,
   input  logic [7:0]        RX_DATA,
   input  logic              RX_VALID,
   output logic              RX_READY,
   output logic              PROG_WE,
   output logic [ADDR_W-1:0] PROG_ADDR,
   output logic [DATA_W-1:0] PROG_DIN,
   output logic              CPU_HOLD,
   output logic              LOAD_DONE,
   output logic              LOAD_ERR
);
   localparam int TO_W = $clog2(TIMEOUT_CYC);

   state_t             state, state_nxt;
   logic               accept, rsv_bad, is_sync, chk_ok, run, expire, err_set;
   logic [HI_BITS-1:0] hi_q;
   logic [7:0]         mid_q, chk_q;
   logic [ADDR_W-1:0]  word_idx, n_last;

   assign accept  = RX_VALID && RX_READY;
   assign rsv_bad = (RX_DATA[7:HI_BITS] != '0);
   assign is_sync = (RX_DATA == SYNC_BYTE);
   assign chk_ok  = (RX_DATA == chk_q);
   assign run     = (state != ST_IDLE) && (state != ST_WRITE);
   assign err_set = expire ||
                    (accept && ((((state == ST_CNT_HI) || (state == ST_B0)) && rsv_bad) ||
                                ((state == ST_CHK) && !chk_ok)));

   loader_timeout #(
      .W        (TO_W),
      .LOAD_VAL (TIMEOUT_CYC - 1)
   ) u_timeout (
      .clk_sys (PROG_CLK),
      .rst_b   (PROG_RST_N),
      .clear   (accept || !run),
      .enable  (run && !accept),
      .expire  (expire)
   );

   always_ff @(posedge PROG_CLK or negedge PROG_RST_N) begin
      if (!PROG_RST_N)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (accept && is_sync) state_nxt = ST_CNT_HI;
         ST_CNT_HI: if (accept) state_nxt = rsv_bad ? ST_IDLE : ST_CNT_LO;
         ST_CNT_LO: if (accept) state_nxt = ST_B0;
         ST_B0:     if (accept) state_nxt = rsv_bad ? ST_IDLE : ST_B1;
         ST_B1:     if (accept) state_nxt = ST_B2;
         ST_B2:     if (accept) state_nxt = ST_WRITE;
         ST_WRITE:  state_nxt = (word_idx == n_last) ? ST_CHK : ST_B0;
         ST_CHK:    if (accept) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
      if (expire)
         state_nxt = ST_IDLE;
   end

   always_comb begin
      RX_READY = 1'b1;
      PROG_WE  = 1'b0;
      CPU_HOLD = 1'b1;
      case (state)
         ST_IDLE:  CPU_HOLD = 1'b0;
         ST_WRITE: begin
            RX_READY = 1'b0;
            PROG_WE  = 1'b1;
         end
         default: ;
      endcase
   end

   // PROG_ADDR/PROG_DIN load only at the B2 handshake so they are stable outside writes
   always_ff @(posedge PROG_CLK or negedge PROG_RST_N) begin
      if (!PROG_RST_N) begin
         hi_q      <= '0;
         mid_q     <= '0;
         chk_q     <= '0;
         word_idx  <= '0;
         n_last    <= '0;
         PROG_ADDR <= '0;
         PROG_DIN  <= '0;
         LOAD_DONE <= 1'b0;
         LOAD_ERR  <= 1'b0;
      end else begin
         LOAD_DONE <= 1'b0;
         if (accept) begin
            case (state)
               ST_IDLE: if (is_sync) begin
                  LOAD_ERR <= 1'b0;
                  chk_q    <= '0;
                  word_idx <= '0;
               end
               ST_CNT_HI: hi_q   <= RX_DATA[HI_BITS-1:0];
               ST_CNT_LO: n_last <= {hi_q, RX_DATA};
               ST_B0: begin
                  hi_q  <= RX_DATA[HI_BITS-1:0];
                  chk_q <= chk_q ^ RX_DATA;
               end
               ST_B1: begin
                  mid_q <= RX_DATA;
                  chk_q <= chk_q ^ RX_DATA;
               end
               ST_B2: begin
                  PROG_DIN  <= {hi_q, mid_q, RX_DATA};
                  PROG_ADDR <= word_idx;
                  chk_q     <= chk_q ^ RX_DATA;
               end
               ST_CHK: if (chk_ok) LOAD_DONE <= 1'b1;
               default: ;
            endcase
         end
         if (state == ST_WRITE)
            word_idx <= word_idx + 1'b1;
         if (err_set)
            LOAD_ERR <= 1'b1;
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frames are built from word lists, and expected writes,
// completion and error status follow directly from how each frame was built.
module tb_prog_loader;
   localparam int TO = 16;

   logic        PROG_CLK = 1'b0;
   logic        PROG_RST_N = 1'b0;
   logic [7:0]  RX_DATA = 8'h00;
   logic        RX_VALID = 1'b0;
   logic        RX_READY, PROG_WE, CPU_HOLD, LOAD_DONE, LOAD_ERR;
   logic [9:0]  PROG_ADDR;
   logic [17:0] PROG_DIN;

   int vectors = 0;
   int miscompares = 0;
   int done_cnt = 0;
   logic [27:0] got_q[$];
   logic [27:0] exp_q[$];
   logic [17:0] wq[$];
   logic [7:0]  frame_q[$];

   prog_loader #(.TIMEOUT_CYC(TO)) dut (
      .PROG_CLK   (PROG_CLK),
      .PROG_RST_N (PROG_RST_N),
      .RX_DATA    (RX_DATA),
      .RX_VALID   (RX_VALID),
      .RX_READY   (RX_READY),
      .PROG_WE    (PROG_WE),
      .PROG_ADDR  (PROG_ADDR),
      .PROG_DIN   (PROG_DIN),
      .CPU_HOLD   (CPU_HOLD),
      .LOAD_DONE  (LOAD_DONE),
      .LOAD_ERR   (LOAD_ERR)
   );

   always #5 PROG_CLK = ~PROG_CLK;

   always @(negedge PROG_CLK) begin
      if (PROG_WE === 1'b1) got_q.push_back({PROG_ADDR, PROG_DIN});
      if (LOAD_DONE === 1'b1) done_cnt++;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clear_obs();
      got_q.delete();
      exp_q.delete();
      done_cnt = 0;
   endtask

   task automatic build_frame(input int n, input bit incr);
      logic [7:0]  chk;
      logic [9:0]  nm1;
      logic [17:0] w;
      chk = 8'h00;
      nm1 = 10'(n - 1);
      wq.delete();
      frame_q.delete();
      frame_q.push_back(8'hA5);
      frame_q.push_back({6'b0, nm1[9:8]});
      frame_q.push_back(nm1[7:0]);
      for (int i = 0; i < n; i++) begin
         w = incr ? 18'(i) : 18'($urandom);
         wq.push_back(w);
         frame_q.push_back({6'b0, w[17:16]});
         frame_q.push_back(w[15:8]);
         frame_q.push_back(w[7:0]);
         chk = chk ^ {6'b0, w[17:16]} ^ w[15:8] ^ w[7:0];
      end
      frame_q.push_back(chk);
   endtask

   task automatic expect_words(input int k);
      for (int i = 0; i < k; i++) exp_q.push_back({10'(i), wq[i]});
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int guard;
      RX_VALID = 1'b0;
      repeat (gap) @(negedge PROG_CLK);
      RX_DATA  = b;
      RX_VALID = 1'b1;
      guard = 0;
      while (RX_READY !== 1'b1 && guard < 8) begin
         @(negedge PROG_CLK);
         guard++;
      end
      if (guard >= 8) begin
         miscompares++;
         $display("FAIL rx_ready_wait got=%b want=1", RX_READY);
      end
      @(negedge PROG_CLK);
      RX_VALID = 1'b0;
   endtask

   task automatic send_range(input int from, input int to, input int max_gap);
      for (int i = from; i < to; i++) send_byte(frame_q[i], $urandom_range(0, max_gap));
   endtask

   task automatic settle();
      repeat (3) @(negedge PROG_CLK);
   endtask

   task automatic test_reset();
      PROG_RST_N = 1'b0;
      repeat (2) @(negedge PROG_CLK);
      vectors++;
      if ({RX_READY, PROG_WE, CPU_HOLD, LOAD_DONE, LOAD_ERR, PROG_ADDR, PROG_DIN} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 18'd0}) begin
         miscompares++;
         $display("FAIL reset_values got rdy=%b we=%b hold=%b done=%b err=%b addr=%h din=%h want 1,0,0,0,0,0,0",
                  RX_READY, PROG_WE, CPU_HOLD, LOAD_DONE, LOAD_ERR, PROG_ADDR, PROG_DIN);
      end
      PROG_RST_N = 1'b1;
      @(negedge PROG_CLK);
   endtask

   task automatic test_single();
      logic [7:0] fr [7];
      fr = '{8'hA5, 8'h00, 8'h00, 8'h03, 8'hFF, 8'hFF, 8'h03};
      clear_obs();
      send_byte(fr[0], 0);
      vectors++;
      if (CPU_HOLD !== 1'b1) begin
         miscompares++;
         $display("FAIL single_hold_after_sync got=%b want=1", CPU_HOLD);
      end
      for (int i = 1; i < 6; i++) send_byte(fr[i], 0);
      send_byte(fr[6], 0);
      vectors++;
      if ({CPU_HOLD, LOAD_DONE} !== 2'b01) begin
         miscompares++;
         $display("FAIL single_after_chk got hold=%b done=%b want hold=0 done=1", CPU_HOLD, LOAD_DONE);
      end
      settle();
      vectors++;
      if (got_q.size() != 1 || got_q[0] !== {10'd0, 18'h3FFFF}) begin
         miscompares++;
         $display("FAIL single_write got n=%0d first=%h want n=1 %h", got_q.size(),
                  (got_q.size() > 0) ? got_q[0] : 28'h0, {10'd0, 18'h3FFFF});
      end
      vectors++;
      if (done_cnt != 1 || LOAD_ERR !== 1'b0) begin
         miscompares++;
         $display("FAIL single_status got done=%0d err=%b want done=1 err=0", done_cnt, LOAD_ERR);
      end
   endtask

   task automatic test_random_frames();
      int n;
      for (int f = 0; f < 5; f++) begin
         n = $urandom_range(1, 24);
         clear_obs();
         build_frame(n, 1'b0);
         expect_words(n);
         send_range(0, frame_q.size(), 3);
         settle();
         vectors++;
         if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL random_count frame=%0d got=%0d want=%0d", f, got_q.size(), exp_q.size());
         end
         foreach (exp_q[i]) begin
            vectors++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
               miscompares++;
               $display("FAIL random_write frame=%0d idx=%0d got=%h want=%h", f, i,
                        (i < got_q.size()) ? got_q[i] : 28'hx, exp_q[i]);
            end
         end
         vectors++;
         if (done_cnt != 1 || LOAD_ERR !== 1'b0 || CPU_HOLD !== 1'b0) begin
            miscompares++;
            $display("FAIL random_status frame=%0d got done=%0d err=%b hold=%b want 1,0,0",
                     f, done_cnt, LOAD_ERR, CPU_HOLD);
         end
      end
   endtask

   task automatic test_full();
      clear_obs();
      build_frame(1024, 1'b1);
      expect_words(1024);
      send_range(0, frame_q.size(), 0);
      settle();
      vectors++;
      if (got_q.size() != 1024) begin
         miscompares++;
         $display("FAIL full_count got=%0d want=1024", got_q.size());
      end
      foreach (exp_q[i]) begin
         vectors++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL full_write idx=%0d got=%h want=%h", i,
                     (i < got_q.size()) ? got_q[i] : 28'hx, exp_q[i]);
         end
      end
      vectors++;
      if (PROG_ADDR !== 10'd1023 || done_cnt != 1 || LOAD_ERR !== 1'b0) begin
         miscompares++;
         $display("FAIL full_end got addr=%0d done=%0d err=%b want addr=1023 done=1 err=0",
                  PROG_ADDR, done_cnt, LOAD_ERR);
      end
   endtask

   task automatic test_bad_chk();
      clear_obs();
      build_frame(2, 1'b0);
      expect_words(2);
      frame_q[frame_q.size()-1] = frame_q[frame_q.size()-1] ^ 8'($urandom_range(1, 255));
      send_range(0, frame_q.size(), 2);
      settle();
      vectors++;
      if (got_q.size() != 2 || got_q[0] !== exp_q[0] || got_q[1] !== exp_q[1]) begin
         miscompares++;
         $display("FAIL badchk_writes got n=%0d want n=2 (%h,%h)", got_q.size(), exp_q[0], exp_q[1]);
      end
      vectors++;
      if ({LOAD_ERR, CPU_HOLD} !== 2'b10 || done_cnt != 0) begin
         miscompares++;
         $display("FAIL badchk_status got err=%b hold=%b done=%0d want err=1 hold=0 done=0",
                  LOAD_ERR, CPU_HOLD, done_cnt);
      end
      clear_obs();
      build_frame(3, 1'b0);
      expect_words(3);
      send_byte(frame_q[0], 0);
      vectors++;
      if (LOAD_ERR !== 1'b0) begin
         miscompares++;
         $display("FAIL badchk_err_clear_on_sync got=%b want=0", LOAD_ERR);
      end
      send_range(1, frame_q.size(), 1);
      settle();
      vectors++;
      if (got_q.size() != 3 || got_q[2] !== exp_q[2] || done_cnt != 1) begin
         miscompares++;
         $display("FAIL badchk_reload got n=%0d done=%0d want n=3 done=1", got_q.size(), done_cnt);
      end
   endtask

   task automatic test_bad_b0();
      clear_obs();
      build_frame(3, 1'b0);
      expect_words(1);
      frame_q[6] = 8'h04;
      for (int i = 7; i < frame_q.size(); i++)
         if (frame_q[i] == 8'hA5) frame_q[i] = 8'h5A;
      send_range(0, 7, 1);
      vectors++;
      if ({LOAD_ERR, CPU_HOLD, RX_READY} !== 3'b101) begin
         miscompares++;
         $display("FAIL badb0_abort got err=%b hold=%b rdy=%b want 1,0,1", LOAD_ERR, CPU_HOLD, RX_READY);
      end
      send_range(7, frame_q.size(), 1);
      settle();
      vectors++;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0] || CPU_HOLD !== 1'b0 || done_cnt != 0) begin
         miscompares++;
         $display("FAIL badb0_writes got n=%0d hold=%b done=%0d want n=1 (%h) hold=0 done=0",
                  got_q.size(), CPU_HOLD, done_cnt, exp_q[0]);
      end
   endtask

   task automatic test_bad_cnt();
      clear_obs();
      send_byte(8'hA5, 0);
      send_byte(8'h04, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      settle();
      vectors++;
      if (LOAD_ERR !== 1'b1 || CPU_HOLD !== 1'b0 || got_q.size() != 0) begin
         miscompares++;
         $display("FAIL badcnt got err=%b hold=%b writes=%0d want err=1 hold=0 writes=0",
                  LOAD_ERR, CPU_HOLD, got_q.size());
      end
   endtask

   task automatic test_timeout();
      clear_obs();
      send_byte(8'hA5, 0);
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      repeat (TO - 1) @(negedge PROG_CLK);
      vectors++;
      if ({LOAD_ERR, CPU_HOLD} !== 2'b01) begin
         miscompares++;
         $display("FAIL timeout_early got err=%b hold=%b want err=0 hold=1", LOAD_ERR, CPU_HOLD);
      end
      @(negedge PROG_CLK);
      vectors++;
      if ({LOAD_ERR, CPU_HOLD} !== 2'b10) begin
         miscompares++;
         $display("FAIL timeout_fire got err=%b hold=%b want err=1 hold=0", LOAD_ERR, CPU_HOLD);
      end
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      settle();
      vectors++;
      if (got_q.size() != 0 || CPU_HOLD !== 1'b0 || done_cnt != 0) begin
         miscompares++;
         $display("FAIL timeout_garbage got writes=%0d hold=%b done=%0d want 0,0,0",
                  got_q.size(), CPU_HOLD, done_cnt);
      end
   endtask

   task automatic test_async_reset();
      clear_obs();
      build_frame(2, 1'b0);
      send_range(0, 4, 0);
      RX_DATA  = frame_q[4];
      RX_VALID = 1'b1;
      #2;
      PROG_RST_N = 1'b0;
      #1;
      vectors++;
      if ({RX_READY, PROG_WE, CPU_HOLD, LOAD_DONE, LOAD_ERR, PROG_ADDR, PROG_DIN} !==
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 18'd0}) begin
         miscompares++;
         $display("FAIL async_reset got rdy=%b we=%b hold=%b done=%b err=%b addr=%h din=%h want 1,0,0,0,0,0,0",
                  RX_READY, PROG_WE, CPU_HOLD, LOAD_DONE, LOAD_ERR, PROG_ADDR, PROG_DIN);
      end
      RX_VALID = 1'b0;
      @(negedge PROG_CLK);
      PROG_RST_N = 1'b1;
      @(negedge PROG_CLK);
      clear_obs();
      build_frame(4, 1'b0);
      expect_words(4);
      send_range(0, frame_q.size(), 2);
      settle();
      vectors++;
      if (got_q.size() != 4) begin
         miscompares++;
         $display("FAIL async_reload_count got=%0d want=4", got_q.size());
      end
      foreach (exp_q[i]) begin
         vectors++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL async_reload_write idx=%0d got=%h want=%h", i,
                     (i < got_q.size()) ? got_q[i] : 28'hx, exp_q[i]);
         end
      end
      vectors++;
      if (done_cnt != 1 || LOAD_ERR !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reload_status got done=%0d err=%b want done=1 err=0", done_cnt, LOAD_ERR);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_random_frames();
      test_full();
      test_bad_chk();
      test_bad_b0();
      test_bad_cnt();
      test_timeout();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
